// File: rtl/hs_fifo_wr_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
// Imported by the picker, the arbiter top and the testbench.
package hs_fifo_wr_arb_pkg;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_MAX_BURST = 4;

    // Wide enough to hold MAX_BURST itself, so the counter can reach it without wrapping.
    function automatic int beatCntWidth(input int maxBurst);
        return $clog2(maxBurst + 1);
    endfunction

    function automatic int reqIdxWidth(input int nReq);
        return (nReq > 1) ? $clog2(nReq) : 1;
    endfunction

endpackage

// File: rtl/hs_fifo_wr_arb_if.sv
// Requester-side and FIFO-write-side handshake bundle for hs_fifo_wr_arb.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface hs_fifo_wr_arb_if #(
    parameter int  N_REQ     = 4,
    parameter type DATA_TYPE = logic [15:0]
);

    logic [N_REQ-1:0] req_valid;
    DATA_TYPE         req_data [N_REQ];
    logic [N_REQ-1:0] req_last;
    logic [N_REQ-1:0] req_ready;

    logic             fifo_full;
    logic             fifo_wr_en;
    DATA_TYPE         fifo_wr_data;
    logic             fifo_wr_last;

    logic [N_REQ-1:0] grant;
    logic             busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data,
        output fifo_wr_last,
        output grant,
        output busy
    );

    modport slave (
        output req_valid,
        output req_data,
        output req_last,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data,
        input  fifo_wr_last,
        input  grant,
        input  busy
    );

endinterface

// File: rtl/hs_fifo_rr_pick.sv
// Combinational round-robin picker: returns the first valid index strictly
// after ptr_i, wrapping modulo N_REQ; ptr_i itself is considered last.
module hs_fifo_rr_pick
    import hs_fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = reqIdxWidth(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(ptr_i) + off) % N_REQ);
            if (valid_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs_fifo_wr_arb.sv
// N-way round-robin arbiter feeding a single FIFO write port, with either
// burst-limited grants or whole-packet grants.
module hs_fifo_wr_arb
    import hs_fifo_wr_arb_pkg::*;
#(
    parameter int    N_REQ          = DEF_N_REQ,
    parameter type   DATA_TYPE      = logic [15:0],
    parameter bool_e EN_PACKET_MODE = FALSE,
    parameter int    MAX_BURST      = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    hs_fifo_wr_arb_if.master  bus
);

    localparam int IDX_W = reqIdxWidth(N_REQ);
    localparam int CNT_W = beatCntWidth(MAX_BURST);

    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grantIdx_q, grantIdx_d;
    logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0] beatCnt_q, beatCnt_d;

    logic [IDX_W-1:0] pickIdx;
    logic             pickFound;

    logic             ownerValid;
    logic             ownerLast;
    logic             accept;
    logic             relGrant;
    logic [CNT_W-1:0] cntInc;

    logic [N_REQ-1:0] readyVec;
    logic [N_REQ-1:0] grantVec;
    logic             busyFlag;
    logic             wrEn;

    hs_fifo_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (rrPtr_q),
        .idx_o   (pickIdx),
        .found_o (pickFound)
    );

    always_comb begin
        ownerValid = bus.req_valid[grantIdx_q];
        ownerLast  = bus.req_last[grantIdx_q];
    end

    // The counter saturates rather than wrapping; in packet mode a long packet may exceed MAX_BURST.
    always_comb begin
        cntInc = (beatCnt_q == CNT_SAT) ? beatCnt_q : beatCnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        grantIdx_d = grantIdx_q;
        rrPtr_d    = rrPtr_q;
        beatCnt_d  = beatCnt_q;
        readyVec   = '0;
        grantVec   = '0;
        busyFlag   = 1'b0;
        accept     = 1'b0;
        relGrant   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pickFound) begin
                    grantIdx_d = pickIdx;
                    beatCnt_d  = '0;
                    state_d    = BUSY;
                end
            end

            BUSY: begin
                busyFlag             = 1'b1;
                grantVec[grantIdx_q] = 1'b1;
                readyVec[grantIdx_q] = !bus.fifo_full;
                accept               = ownerValid && !bus.fifo_full;

                if (accept) begin
                    beatCnt_d = cntInc;
                end

                // A packet owner keeps the grant through valid gaps; a burst owner gives it up.
                if (EN_PACKET_MODE == TRUE) begin
                    relGrant = accept && ownerLast;
                end else begin
                    relGrant = (accept && (cntInc == CNT_LIMIT)) || !ownerValid;
                end

                if (relGrant) begin
                    rrPtr_d = grantIdx_q;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wrEn = accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grantIdx_q <= '0;
            rrPtr_q    <= PTR_RESET;
            beatCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grantIdx_q <= grantIdx_d;
            rrPtr_q    <= rrPtr_d;
            beatCnt_q  <= beatCnt_d;
        end
    end

    assign bus.req_ready    = readyVec;
    assign bus.grant        = grantVec;
    assign bus.busy         = busyFlag;
    assign bus.fifo_wr_en   = wrEn;
    assign bus.fifo_wr_data = bus.req_data[grantIdx_q];
    assign bus.fifo_wr_last = ownerLast;

endmodule

// File: tb/tb_hs_fifo_wr_arb.sv
// Directed testbench: burst-mode arbiter (dutA) and packet-mode arbiter (dutB)
// driven cycle by cycle against hand-computed grant/handshake expectations.
module tb_hs_fifo_wr_arb;
    import hs_fifo_wr_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int beatA [4];
    int beatB [4];

    always #5 clk = ~clk;

    hs_fifo_wr_arb_if #(.N_REQ(4), .DATA_TYPE(logic [15:0])) busA ();
    hs_fifo_wr_arb_if #(.N_REQ(4), .DATA_TYPE(logic [15:0])) busB ();

    hs_fifo_wr_arb #(
        .N_REQ          (4),
        .DATA_TYPE      (logic [15:0]),
        .EN_PACKET_MODE (FALSE),
        .MAX_BURST      (4)
    ) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA.master)
    );

    hs_fifo_wr_arb #(
        .N_REQ          (4),
        .DATA_TYPE      (logic [15:0]),
        .EN_PACKET_MODE (TRUE),
        .MAX_BURST      (4)
    ) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB.master)
    );

    // Payload encodes requester tag in the top nibble and beat number below it.
    function automatic logic [15:0] mkData(input int tagId, input int beat);
        return 16'((tagId << 12) + (beat & 'hFFF));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit selB, input logic [3:0] valid,
                                 input logic [3:0] last, input logic full);
        for (int i = 0; i < 4; i++) begin
            if (selB) busB.req_data[i] = mkData(i + 8, beatB[i]);
            else      busA.req_data[i] = mkData(i, beatA[i]);
        end
        if (selB) begin
            busB.req_valid = valid;
            busB.req_last  = last;
            busB.fifo_full = full;
        end else begin
            busA.req_valid = valid;
            busA.req_last  = last;
            busA.fifo_full = full;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkCycle(input bit selB, input string tag, input logic [3:0] expGrant,
                              input logic expBusy, input logic [3:0] expReady, input logic expWrEn);
        if (selB) begin
            checkOutput({tag, " grant"}, 32'(busB.grant),      32'(expGrant));
            checkOutput({tag, " busy"},  32'(busB.busy),       32'(expBusy));
            checkOutput({tag, " ready"}, 32'(busB.req_ready),  32'(expReady));
            checkOutput({tag, " wr_en"}, 32'(busB.fifo_wr_en), 32'(expWrEn));
        end else begin
            checkOutput({tag, " grant"}, 32'(busA.grant),      32'(expGrant));
            checkOutput({tag, " busy"},  32'(busA.busy),       32'(expBusy));
            checkOutput({tag, " ready"}, 32'(busA.req_ready),  32'(expReady));
            checkOutput({tag, " wr_en"}, 32'(busA.fifo_wr_en), 32'(expWrEn));
        end
    endtask

    task automatic checkData(input bit selB, input string tag, input logic [15:0] expData,
                             input logic expLast);
        if (selB) begin
            checkOutput({tag, " wr_data"}, 32'(busB.fifo_wr_data), 32'(expData));
            checkOutput({tag, " wr_last"}, 32'(busB.fifo_wr_last), 32'(expLast));
        end else begin
            checkOutput({tag, " wr_data"}, 32'(busA.fifo_wr_data), 32'(expData));
            checkOutput({tag, " wr_last"}, 32'(busA.fifo_wr_last), 32'(expLast));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1, 4'b0000, 4'b0000, 1'b0);
        #10;
        checkCycle(0, "rstA", 4'b0000, 1'b0, 4'b0000, 1'b0);
        checkCycle(1, "rstB", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        rst_n = 1'b1;

        // Burst mode, all requesting: 0,1,2,3,0 with four beats each and a bubble between.
        for (int g = 0; g < 5; g++) begin
            applyStimulus(0, 4'b1111, 4'b0000, 1'b0);
            checkCycle(0, "rrBubble", 4'b0000, 1'b0, 4'b0000, 1'b0);
            tick();
            for (int b = 0; b < 4; b++) begin
                applyStimulus(0, 4'b1111, 4'b0000, 1'b0);
                checkCycle(0, "rrBurst", 4'(1 << order[g]), 1'b1, 4'(1 << order[g]), 1'b1);
                checkData(0, "rrBurst", mkData(order[g], beatA[order[g]]), 1'b0);
                tick();
                beatA[order[g]]++;
            end
        end

        // fifo_full for three cycles mid-burst on requester 2.
        applyStimulus(0, 4'b0100, 4'b0000, 1'b0);
        checkCycle(0, "fullBubble", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        for (int b = 0; b < 2; b++) begin
            applyStimulus(0, 4'b0100, 4'b0000, 1'b0);
            checkCycle(0, "fullPre", 4'b0100, 1'b1, 4'b0100, 1'b1);
            checkData(0, "fullPre", mkData(2, beatA[2]), 1'b0);
            tick();
            beatA[2]++;
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 4'b0100, 4'b0000, 1'b1);
            checkCycle(0, "fullHold", 4'b0100, 1'b1, 4'b0000, 1'b0);
            tick();
        end
        for (int b = 0; b < 2; b++) begin
            applyStimulus(0, 4'b0100, 4'b0000, 1'b0);
            checkCycle(0, "fullPost", 4'b0100, 1'b1, 4'b0100, 1'b1);
            checkData(0, "fullPost", mkData(2, beatA[2]), 1'b0);
            tick();
            beatA[2]++;
        end
        applyStimulus(0, 4'b0100, 4'b0000, 1'b0);
        checkCycle(0, "fullRelease", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        // Lone requester is re-granted after the bubble; dropping valid then releases it.
        applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
        checkCycle(0, "soloRegrant", 4'b0100, 1'b1, 4'b0100, 1'b0);
        tick();

        // Requester 1 sends two beats then drops valid; pointer must land on 1.
        applyStimulus(0, 4'b0010, 4'b0000, 1'b0);
        checkCycle(0, "dropBubble", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        for (int b = 0; b < 2; b++) begin
            applyStimulus(0, 4'b0010, 4'b0000, 1'b0);
            checkCycle(0, "dropBeat", 4'b0010, 1'b1, 4'b0010, 1'b1);
            checkData(0, "dropBeat", mkData(1, beatA[1]), 1'b0);
            tick();
            beatA[1]++;
        end
        applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
        checkCycle(0, "dropIdleOwner", 4'b0010, 1'b1, 4'b0010, 1'b0);
        tick();
        applyStimulus(0, 4'b1111, 4'b0000, 1'b0);
        checkCycle(0, "dropReleased", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
        checkCycle(0, "ptrAfterDrop", 4'b0100, 1'b1, 4'b0100, 1'b0);
        tick();
        applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
        checkCycle(0, "aIdleEnd", 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Packet mode: requester 2 sends six beats with a valid gap after beat 3.
        applyStimulus(1, 4'b0100, 4'b0000, 1'b0);
        checkCycle(1, "pktBubble", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        for (int b = 0; b < 6; b++) begin
            if (b == 3) begin
                applyStimulus(1, 4'b0001, 4'b0000, 1'b0);
                checkCycle(1, "pktGap", 4'b0100, 1'b1, 4'b0100, 1'b0);
                tick();
            end
            applyStimulus(1, 4'b0101, (b == 5) ? 4'b0100 : 4'b0000, 1'b0);
            checkCycle(1, "pktBeat", 4'b0100, 1'b1, 4'b0100, 1'b1);
            checkData(1, "pktBeat", mkData(10, beatB[2]), (b == 5));
            tick();
            beatB[2]++;
        end
        applyStimulus(1, 4'b0001, 4'b0000, 1'b0);
        checkCycle(1, "pktRelBubble", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        applyStimulus(1, 4'b0001, 4'b0000, 1'b0);
        checkCycle(1, "pktNext", 4'b0001, 1'b1, 4'b0001, 1'b1);
        checkData(1, "pktNext", mkData(8, beatB[0]), 1'b0);
        tick();
        beatB[0]++;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1, 4'b0000, 4'b0000, 1'b0);
            checkCycle(1, "pktHoldGap", 4'b0001, 1'b1, 4'b0001, 1'b0);
            tick();
        end
        applyStimulus(1, 4'b0001, 4'b0001, 1'b0);
        checkCycle(1, "pktNextLast", 4'b0001, 1'b1, 4'b0001, 1'b1);
        checkData(1, "pktNextLast", mkData(8, beatB[0]), 1'b1);
        tick();
        beatB[0]++;

        // Reset asserted mid-packet on requester 3.
        applyStimulus(1, 4'b1000, 4'b0000, 1'b0);
        checkCycle(1, "rstMidBubble", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        applyStimulus(1, 4'b1000, 4'b0000, 1'b0);
        checkCycle(1, "rstMidBeat", 4'b1000, 1'b1, 4'b1000, 1'b1);
        checkData(1, "rstMidBeat", mkData(11, beatB[3]), 1'b0);
        tick();
        beatB[3]++;
        applyStimulus(1, 4'b1000, 4'b0000, 1'b0);
        checkCycle(1, "rstMidOwned", 4'b1000, 1'b1, 4'b1000, 1'b1);
        rst_n = 1'b0;
        #1;
        checkCycle(1, "rstMidAsync", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        applyStimulus(1, 4'b1111, 4'b0000, 1'b0);
        checkCycle(1, "rstPostIdle", 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        applyStimulus(1, 4'b1111, 4'b0000, 1'b0);
        checkCycle(1, "rstPostFirst", 4'b0001, 1'b1, 4'b0001, 1'b1);
        checkData(1, "rstPostFirst", mkData(8, beatB[0]), 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
